// File: rtl/audio_i2s_transmitter.sv
// audio_i2s_transmitter
//   Serializes stereo two's-complement PCM samples into an I2S stream for the
//   codec DAC. BCLK and LRCK are derived from the system clock by integer
//   division. One stereo sample is accepted per frame through a valid/ready
//   handshake backed by a one-entry holding buffer.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high
//   sample_left   left channel sample  [SAMPLE_WIDTH]
//   sample_right  right channel sample [SAMPLE_WIDTH]
//   sample_valid  producer offers a stereo sample
//   sample_ready  holding buffer empty; transfer on valid && ready
//   mute          frames loaded while high carry zeros (buffer still consumed)
//   aud_bclk      I2S bit clock
//   aud_daclrck   frame clock, 0 = left, 1 = right
//   aud_dacdat    serial data, MSB one BCLK after the LRCK edge
//   frame_start   one-cycle pulse on each frame load
//   underrun      one-cycle pulse when a frame loads with an empty buffer
module audio_i2s_transmitter #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned BCLK_HALF    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    mute,
  output logic                    aud_bclk,
  output logic                    aud_daclrck,
  output logic                    aud_dacdat,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned      DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0]        div_q;
  logic                    bclk_q;
  logic [5:0]              bit_cnt_q;
  logic                    lrck_q;
  logic                    dat_q;
  logic                    ready_q;
  logic [SAMPLE_WIDTH-1:0] buf_l_q;
  logic [SAMPLE_WIDTH-1:0] buf_r_q;
  logic [SAMPLE_WIDTH-1:0] sh_l_q;
  logic [SAMPLE_WIDTH-1:0] sh_r_q;
  logic                    fs_q;
  logic                    und_q;

  logic                    div_wrap;
  logic                    fall_evt;
  logic                    frame_wrap;
  logic                    accept;
  logic [5:0]              bit_cnt_d;
  logic                    dat_d;
  logic [SAMPLE_WIDTH-1:0] chan;

  always_comb begin
    div_wrap   = (div_q == DIV_LAST);
    fall_evt   = div_wrap && bclk_q;
    bit_cnt_d  = bit_cnt_q + 6'd1;
    frame_wrap = fall_evt && (bit_cnt_q == 6'd63);
    accept     = sample_valid && ready_q;
    chan       = bit_cnt_d[5] ? sh_r_q : sh_l_q;
    // Slot p (1..SAMPLE_WIDTH) carries bit SAMPLE_WIDTH-p; slot 0 and the
    // trailing slots are zero. Registers are indexed, never shifted.
    dat_d = 1'b0;
    for (int unsigned i = 0; i < SAMPLE_WIDTH; i++) begin
      if (32'(bit_cnt_d[4:0]) == SAMPLE_WIDTH - i) begin
        dat_d = chan[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      lrck_q    <= 1'b1;
      dat_q     <= 1'b0;
      ready_q   <= 1'b1;
      buf_l_q   <= '0;
      buf_r_q   <= '0;
      sh_l_q    <= '0;
      sh_r_q    <= '0;
      fs_q      <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      fs_q  <= 1'b0;
      und_q <= 1'b0;

      if (div_wrap) begin
        div_q  <= '0;
        bclk_q <= ~bclk_q;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      if (fall_evt) begin
        bit_cnt_q <= bit_cnt_d;
        lrck_q    <= bit_cnt_d[5];
        dat_q     <= dat_d;
      end

      // Load uses the pre-edge buffer state; a same-edge accept refills it.
      if (frame_wrap) begin
        fs_q  <= 1'b1;
        und_q <= ready_q;
        if (!ready_q && !mute) begin
          sh_l_q <= buf_l_q;
          sh_r_q <= buf_r_q;
        end else begin
          sh_l_q <= '0;
          sh_r_q <= '0;
        end
      end

      if (accept) begin
        buf_l_q <= sample_left;
        buf_r_q <= sample_right;
        ready_q <= 1'b0;
      end else if (frame_wrap) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign sample_ready = ready_q;
  assign aud_bclk     = bclk_q;
  assign aud_daclrck  = lrck_q;
  assign aud_dacdat   = dat_q;
  assign frame_start  = fs_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_audio_i2s_transmitter.sv
module tb_audio_i2s_transmitter;

  localparam int unsigned SW    = 16;
  localparam int unsigned BH    = 8;
  localparam int unsigned FRAME = 128 * BH;
  localparam int unsigned FIRST = 2 * BH;

  logic          clock = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic          mute;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
  logic          frame_start;
  logic          underrun;

  always #10 clock = ~clock;

  audio_i2s_transmitter #(
    .SAMPLE_WIDTH(SW),
    .BCLK_HALF   (BH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_left (sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .mute        (mute),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected 64-slot frame: slot s, channel slot p = s mod 32,
  // bit = sample[SW-p] for 1 <= p <= SW, else 0; left for s < 32.
  function automatic logic [63:0] frame_bits(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [63:0] b;
    logic [SW-1:0] smp;
    int p;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      p   = s % 32;
      smp = (s < 32) ? l : r;
      if (p >= 1 && p <= int'(SW)) b[s] = smp[int'(SW) - p];
    end
    return b;
  endfunction

  typedef struct {
    int unsigned cyc;
    logic [63:0] bits;
    logic        und;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: cycle count since reset, frame loads every FRAME clocks
  // starting at FIRST, one-entry buffer.
  int unsigned   cyc = 0;
  logic          m_full = 1'b0;
  logic          m_acc = 1'b0;
  logic [SW-1:0] m_l = '0;
  logic [SW-1:0] m_r = '0;

  initial begin
    exp_t e;
    logic acc;
    forever begin
      @(posedge clock);
      if (reset) begin
        cyc    = 0;
        m_full = 1'b0;
        m_acc  = 1'b0;
      end else begin
        cyc = cyc + 1;
        acc = sample_valid && !m_full;
        if (cyc >= FIRST && (cyc - FIRST) % FRAME == 0) begin
          e.cyc  = cyc;
          e.und  = !m_full;
          e.bits = (m_full && !mute) ? frame_bits(m_l, m_r) : 64'd0;
          exp_q.push_back(e);
          m_full = 1'b0;
        end
        if (acc) begin
          m_full = 1'b1;
          m_l    = sample_left;
          m_r    = sample_right;
        end
        m_acc = acc;
      end
    end
  end

  // Monitor: pops an expectation on each frame_start and decodes the next
  // 64 bits on BCLK rising edges.
  logic        prev_bclk = 1'b0;
  bit          decoding = 1'b0;
  bit          rise_seen = 1'b0;
  int unsigned slot = 0;
  int unsigned last_rise = 0;
  int unsigned frames_done = 0;
  logic [63:0] got = '0;
  exp_t        cur;

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        decoding  = 1'b0;
        rise_seen = 1'b0;
        prev_bclk = 1'b0;
      end else begin
        chk("sample_ready", 64'(sample_ready), 64'(!m_full));
        if (frame_start) begin
          if (decoding) chk("frame_truncated", 64'(slot), 64'(64));
          chk("frame_start_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("frame_start_cycle", 64'(cyc), 64'(cur.cyc));
            chk("underrun", 64'(underrun), 64'(cur.und));
          end
          decoding = (cur.cyc == cyc);
          slot     = 0;
          got      = '0;
        end else begin
          chk("underrun_without_frame", 64'(underrun), 64'(0));
        end
        if (aud_bclk && !prev_bclk) begin
          if (rise_seen) chk("bclk_period", 64'(cyc - last_rise), 64'(2 * BH));
          rise_seen = 1'b1;
          last_rise = cyc;
          if (decoding) begin
            chk("daclrck", 64'(aud_daclrck), 64'(slot >= 32));
            got[slot] = aud_dacdat;
            slot++;
            if (slot == 64) begin
              chk("frame_data", got, cur.bits);
              decoding = 1'b0;
              frames_done++;
            end
          end
        end
        prev_bclk = aud_bclk;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_frames(input int unsigned k);
    int unsigned target;
    int unsigned n;
    target = frames_done + k;
    n = 0;
    while (frames_done < target && n < (k + 2) * FRAME) begin
      tick();
      n++;
    end
    chk("wait_frames_timeout", 64'(frames_done >= target), 64'(1));
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int unsigned n;
    n = 0;
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 4 * FRAME);
    chk("accept_timeout", 64'(m_acc), 64'(1));
    sample_valid = 1'b0;
    sample_left  = SW'($urandom);
    sample_right = SW'($urandom);
  endtask

  task automatic flush();
    int unsigned n;
    n = 0;
    while (m_full && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("buffer_drain_timeout", 64'(m_full), 64'(0));
    wait_frames(1);
  endtask

  task automatic check_reset_vals();
    chk("rst_bclk",        64'(aud_bclk),     64'(0));
    chk("rst_daclrck",     64'(aud_daclrck),  64'(1));
    chk("rst_dacdat",      64'(aud_dacdat),   64'(0));
    chk("rst_ready",       64'(sample_ready), 64'(1));
    chk("rst_frame_start", 64'(frame_start),  64'(0));
    chk("rst_underrun",    64'(underrun),     64'(0));
  endtask

  initial begin
    repeat (90000) @(posedge clock);
    n_checks++;
    n_fails++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    int unsigned nl;
    int unsigned n;
    reset        = 1'b1;
    sample_valid = 1'b0;
    mute         = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals();
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Idle: zero frames, underrun every frame.
    wait_frames(2);

    // Known pattern.
    send(16'hA5C3, 16'h8001);
    flush();

    // Streaming: each new sample accepted right after the previous load.
    for (int k = 0; k < 4; k++) send(SW'($urandom), SW'($urandom));
    flush();

    // Offer valid exactly on a frame-load edge.
    nl = FIRST + ((cyc - FIRST) / FRAME + 1) * FRAME;
    n  = 0;
    while (cyc != nl - 1 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    sample_valid = 1'b1;
    sample_left  = 16'h1357;
    sample_right = 16'hFACE;
    tick();
    sample_valid = 1'b0;
    sample_left  = SW'($urandom);
    sample_right = SW'($urandom);
    wait_frames(2);

    // Muted frame consumes the buffer without underrun.
    send(16'h7FFF, 16'h7FFF);
    mute = 1'b1;
    flush();
    mute = 1'b0;
    chk("mute_ready_back", 64'(sample_ready), 64'(1));

    // Random gaps, values and mute.
    for (int k = 0; k < 8; k++) begin
      mute = ($urandom_range(3) == 0);
      repeat ($urandom_range(1200)) tick();
      send(SW'($urandom), SW'($urandom));
    end
    mute = 1'b0;
    flush();

    // Reset mid-left-channel with a second sample buffered.
    send(16'h4321, 16'hBEEF);
    send(16'h0F0F, 16'hF0F0);
    repeat (200) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    wait_frames(1);

    chk("expect_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/audio_i2s_transmitter.md
Name: audio_i2s_transmitter

Overview:
- Serializes stereo PCM samples into an I2S stream for the board audio codec DAC (BCLK, DACLRCK, DACDAT); runs off the 50 MHz system clock.
- Generates its own bit clock and frame clock by integer division.
- Sits between the game sound-effect logic (sample producer) and the codec pins.
- Accepts one stereo sample per frame through a valid/ready handshake with a one-entry holding buffer.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel sample; legal range 8..31.
- BCLK_HALF, 8, system clocks per BCLK half-period; legal minimum 2. Default gives a frame of 1024 clocks, fs ≈ 48.83 kHz at 50 MHz.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- sample_left  in  SAMPLE_WIDTH  left sample, two's complement.
- sample_right  in  SAMPLE_WIDTH  right sample, two's complement.
- sample_valid  in  1  producer has a stereo sample.
- sample_ready  out  1  holding buffer empty; transfer occurs when valid && ready on a clock edge.
- mute  in  1  when high, frames loaded send zeros; the buffer is still consumed.
- aud_bclk  out  1  I2S bit clock.
- aud_daclrck  out  1  frame clock; 0 = left channel, 1 = right channel.
- aud_dacdat  out  1  serial data.
- frame_start  out  1  one-cycle pulse on each frame load.
- underrun  out  1  one-cycle pulse when a frame loads with an empty buffer.

Behaviour:
- Reset (all registers updated on the clock edge where reset is high):
  - div_cnt=0, aud_bclk=0, bit_cnt=63, aud_daclrck=1, aud_dacdat=0.
  - Buffer empty (sample_ready=1); shift registers=0; frame_start=0; underrun=0.
  - Reset asserted mid-frame aborts the frame immediately; a sample held in the buffer is discarded.
- BCLK generation:
  - div_cnt counts 0..BCLK_HALF-1.
  - At BCLK_HALF-1: div_cnt→0 and aud_bclk toggles; otherwise div_cnt increments.
- Falling-edge event: a cycle where aud_bclk toggles 1→0. On it:
  - bit_cnt increments modulo 64.
  - aud_daclrck takes the new bit_cnt[5].
  - aud_dacdat takes the bit for the new slot.
  - Nothing else changes on rising-edge events.
- Slot encoding:
  - Channel slot p = new bit_cnt[4:0].
  - aud_dacdat = channel_shift[SAMPLE_WIDTH-p] for 1 ≤ p ≤ SAMPLE_WIDTH, else 0.
  - This is standard I2S: MSB one BCLK after the LRCK edge, trailing slots zero.
  - Left uses the left shift register while bit_cnt<32, right otherwise.
- Frame load: on the falling-edge event where bit_cnt wraps 63→0.
  - Buffer full and mute=0: shift registers ← buffer contents.
  - Buffer full and mute=1: shift registers ← 0.
  - Buffer empty: shift registers ← 0 and underrun pulses for 1 cycle.
  - In all cases: buffer becomes empty and frame_start pulses for 1 cycle (same cycle as underrun).
- First frame load after reset occurs at the 2*BCLK_HALF-th edge after reset deasserts; at default, clock cycle 16.
- Handshake:
  - sample_ready = buffer empty, registered.
  - Accepting a sample sets ready=0 on the next cycle.
  - Producer data must be held only while valid && !ready.
- Simultaneous accept and frame load: the load sees the pre-edge state, so the buffer is empty, the frame is zero, and underrun pulses. The accepted sample lands in the buffer for the next frame, and ready stays 0.
- Latency: a sample accepted before a frame load has its left MSB on aud_dacdat from the first falling edge after bit_cnt=0, i.e. 2*BCLK_HALF clocks after frame_start.
- No sample is dropped or duplicated.
- The frame period is exactly 128*BCLK_HALF clocks.
- Outputs are glitch-free registers.

Test Plan:
- Reset then idle, no valid:
  - aud_bclk period is 16 clocks.
  - aud_daclrck period is 1024 clocks, low for 512.
  - frame_start and underrun pulse every 1024 clocks.
  - aud_dacdat is always 0.
- Left=16'hA5C3, right=16'h8001, valid held until accepted, one frame:
  - Decode aud_dacdat on aud_bclk rising edges: slot 1..16 give A5C3 MSB-first, then 8001 in the right half.
  - Slots 0 and 17..31 read 0.
  - No underrun on that frame.
- Producer streams a new sample immediately after each frame_start for 4 frames: four distinct values appear in order, no underrun, sample_ready low between frames.
- Offer valid in exactly the frame-load cycle: that frame is zero with underrun=1; the sample appears in the following frame.
- mute=1 with a buffered sample 16'h7FFF: the frame outputs zeros, the buffer is consumed (ready returns 1), and there is no underrun.
- Assert reset for one cycle while the left channel is mid-serialization with a buffered sample:
  - All outputs return to reset values next cycle and the buffer is empty.
  - The next frame_start arrives 16 clocks after reset deasserts and carries zeros.
